// File: rtl/exe_mem_pipe_reg.sv
// EX/MEM pipeline register for the N-wide in-order core: per-lane valid/control
// qualification, squash of lanes younger than the oldest taken branch, stall and flush.
module exe_mem_pipe_reg #(
  parameter int LANES    = 2,
  parameter int D_WIDTH  = 32,
  parameter int WA_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_stall,
  input  logic                        i_flush,
  input  logic [LANES-1:0]            i_valid,
  input  logic [LANES-1:0]            i_PCSrc,
  input  logic [LANES-1:0]            i_RegWrite,
  input  logic [LANES-1:0]            i_MemtoReg,
  input  logic [LANES-1:0]            i_MemWrite,
  input  logic [LANES*D_WIDTH-1:0]    i_ALUResultE,
  input  logic [LANES*D_WIDTH-1:0]    i_WriteDataE,
  input  logic [LANES*WA_WIDTH-1:0]   i_WAE,
  output logic [LANES-1:0]            o_validM,
  output logic [LANES-1:0]            o_PCSrcM,
  output logic [LANES-1:0]            o_RegWriteM,
  output logic [LANES-1:0]            o_MemtoRegM,
  output logic [LANES-1:0]            o_MemWriteM,
  output logic [LANES*D_WIDTH-1:0]    o_ALUResultM,
  output logic [LANES*D_WIDTH-1:0]    o_WriteDataM,
  output logic [LANES*WA_WIDTH-1:0]   o_WAM,
  output logic                        o_redirectM,
  output logic [2:0]                  o_redirect_laneM
);

  logic [LANES-1:0] taken_p0;
  logic [LANES-1:0] keep_p0;
  logic [LANES-1:0] vld_p0;
  logic             redir_p0;
  logic [2:0]       lane_p0;

  assign taken_p0 = i_valid & i_PCSrc;

  // Stage p0: find the oldest taken branch; every younger lane is dropped.
  always_comb begin
    keep_p0  = '1;
    redir_p0 = 1'b0;
    lane_p0  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (redir_p0) begin
        keep_p0[k] = 1'b0;
      end else if (taken_p0[k]) begin
        redir_p0 = 1'b1;
        lane_p0  = 3'(k);
      end
    end
  end

  assign vld_p0 = i_valid & keep_p0;

  logic [LANES-1:0]          vld_p1;
  logic [LANES-1:0]          pcsrc_p1;
  logic [LANES-1:0]          regwrite_p1;
  logic [LANES-1:0]          memtoreg_p1;
  logic [LANES-1:0]          memwrite_p1;
  logic                      redir_p1;
  logic [2:0]                lane_p1;
  logic [LANES*D_WIDTH-1:0]  alu_p1;
  logic [LANES*D_WIDTH-1:0]  wdata_p1;
  logic [LANES*WA_WIDTH-1:0] wa_p1;

  // Stage p1: control clears on flush (even while stalled), holds on stall.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      vld_p1      <= '0;
      pcsrc_p1    <= '0;
      regwrite_p1 <= '0;
      memtoreg_p1 <= '0;
      memwrite_p1 <= '0;
      redir_p1    <= 1'b0;
      lane_p1     <= '0;
    end else if (!i_stall) begin
      vld_p1      <= vld_p0;
      pcsrc_p1    <= i_PCSrc    & vld_p0;
      regwrite_p1 <= i_RegWrite & vld_p0;
      memtoreg_p1 <= i_MemtoReg & vld_p0;
      memwrite_p1 <= i_MemWrite & vld_p0;
      redir_p1    <= redir_p0;
      lane_p1     <= lane_p0;
    end
  end

  // Data is not qualified by valid; it only freezes on stall or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_p1   <= '0;
      wdata_p1 <= '0;
      wa_p1    <= '0;
    end else if (!i_stall && !i_flush) begin
      alu_p1   <= i_ALUResultE;
      wdata_p1 <= i_WriteDataE;
      wa_p1    <= i_WAE;
    end
  end

  assign o_validM         = vld_p1;
  assign o_PCSrcM         = pcsrc_p1;
  assign o_RegWriteM      = regwrite_p1;
  assign o_MemtoRegM      = memtoreg_p1;
  assign o_MemWriteM      = memwrite_p1;
  assign o_ALUResultM     = alu_p1;
  assign o_WriteDataM     = wdata_p1;
  assign o_WAM            = wa_p1;
  assign o_redirectM      = redir_p1;
  assign o_redirect_laneM = lane_p1;

endmodule

// File: doc/exe_mem_pipe_reg.md
# exe_mem_pipe_reg

Parametrised EX/MEM pipeline register for the N-wide in-order superscalar core, the successor to the fixed two-lane EX/MEM register. It carries each issue lane's ALU result, store data, write address and control bits into the MEM stage. It also adds per-lane valid bits, a stall hold, a pipeline flush and in-bundle squashing of lanes younger than a taken branch.

## Interface
Parameters:
- LANES, 2, issue lanes; lane 0 is oldest in program order; legal range 1..8
- D_WIDTH, 32, data width of ALU result and store data
- WA_WIDTH, 4, register write-address width

Ports (lane k of a packed bus occupies [k*W +: W]):
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_stall  in  1  hold all outputs this cycle (MEM stage not ready)
- i_flush  in  1  kill all lanes this cycle (redirect from a later stage)
- i_valid  in  LANES  lane carries a real instruction
- i_PCSrc  in  LANES  lane is a taken branch
- i_RegWrite  in  LANES  lane writes register file
- i_MemtoReg  in  LANES  lane writeback selects memory data
- i_MemWrite  in  LANES  lane stores to memory
- i_ALUResultE  in  LANES*D_WIDTH  per-lane ALU result
- i_WriteDataE  in  LANES*D_WIDTH  per-lane store data
- i_WAE  in  LANES*WA_WIDTH  per-lane destination register
- o_validM, o_PCSrcM, o_RegWriteM, o_MemtoRegM, o_MemWriteM  out  LANES each  registered control
- o_ALUResultM, o_WriteDataM  out  LANES*D_WIDTH  registered data
- o_WAM  out  LANES*WA_WIDTH  registered write address
- o_redirectM  out  1  registered: some surviving lane has PCSrc set
- o_redirect_laneM  out  3  registered index of the oldest such lane; 0 when o_redirectM=0

## Operation
- Effective control for lane k: ctl_k = i_X[k] & i_valid[k] for X in {PCSrc, RegWrite, MemtoReg, MemWrite}. Control bits of an invalid lane are never registered as 1.
- Squash: let b be the lowest k with i_valid[k] & i_PCSrc[k]. Every lane j>b loads valid=0 and all four control bits 0. Lane b and older lanes are unaffected.
- Data fields (ALUResult, WriteData, WA) of every lane load unconditionally on a load cycle, including squashed or invalid lanes. They are not qualified by valid.
- Redirect: o_redirectM is 1 when a b exists, and o_redirect_laneM = b. Both are computed from the same cycle's inputs and updated only on load cycles.
- Priority on each rising edge:
  - rst: all outputs ← 0.
  - Else i_flush: o_validM, all control outputs, o_redirectM and o_redirect_laneM ← 0. Data outputs hold. Flush overrides stall.
  - Else i_stall: every output holds its value.
  - Else load: outputs take the squashed, qualified inputs.
- No combinational path from inputs to outputs.

## Timing
- Latency 1 cycle: inputs sampled at edge n appear on outputs after edge n.
- Reset value of every output is 0, valid from the first edge with rst=1. Reset asserted mid-stall or mid-flush still clears everything on that edge.
- Stall of any length holds the state exactly. The first cycle with i_stall=0 loads fresh inputs; there is no replay buffer, so upstream must also hold.
- i_flush asserted together with i_stall clears control on that edge. Subsequent stalled cycles hold the cleared state.
- Boundary cases:
  - Taken branch in the youngest lane (LANES-1): squashes nothing.
  - All lanes invalid: every control output is 0 and o_redirectM=0.
  - Multiple taken branches in one bundle: only the oldest is honoured.

## Test plan
- Reset: rst=1 for 2 cycles with all inputs at 1 and ALU result 32'hFFFF_FFFF → every output 0. Release, load lane0 ALU=32'h1234, WA=4'd3, RegWrite=1, valid=1 → next cycle o_ALUResultM[31:0]=32'h1234, o_WAM[3:0]=3, o_RegWriteM[0]=1.
- Squash: LANES=2, valid=2'b11, PCSrc=2'b01, RegWrite=2'b11, MemWrite=2'b10 → o_validM=2'b01, o_RegWriteM=2'b01, o_MemWriteM=2'b00, o_redirectM=1, o_redirect_laneM=0. Lane1 data still loaded.
- Invalid qualify: valid=2'b10, RegWrite=2'b11, PCSrc=2'b01 → o_RegWriteM=2'b10, o_redirectM=0, o_validM=2'b10.
- Stall: load ALU lane1=32'hA5A5_0000, then hold i_stall=1 for 3 cycles while inputs change → outputs unchanged for all 3 cycles; the first unstalled edge loads the new inputs.
- Flush vs stall: registered o_validM=2'b11 with ALU=32'h55; assert i_flush=1 and i_stall=1 → o_validM=0, all control bits 0, o_ALUResultM still 32'h55.
- Parameter sweep LANES=1 and LANES=4, D_WIDTH=64: taken branch in lane 2 of 4 with all valid → o_validM=4'b0111, o_redirect_laneM=2. Lane 3 data loaded with control bits 0.
